// File: rtl/gf2m_inverse_seq.sv
// GF(2^M) multiplicative inverse z = x^(2^M-2) by iterative square-and-multiply, fixed latency M-1.
// Optional zero-operand flag output enabled by defining GF_INV_ZERO_FLAG_EN.
module gf2m_inverse_seq #(
   parameter int         M    = 6,
   parameter logic [M:0] POLY = 7'b1000011
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         start,
   input  logic [M-1:0] x,
   output logic         busy,
   output logic         done,
   output logic [M-1:0] z
`ifdef GF_INV_ZERO_FLAG_EN
   ,
   output logic         zero_err
`endif
);

   localparam int CW = $clog2(M + 1);
   typedef logic [2*M-2:0] wide_t;

   typedef enum logic {IDLE, CALC} state_t;

   state_t        state, next_state;
   logic [M-1:0]  acc, sq;
   logic [CW-1:0] cnt;
`ifdef GF_INV_ZERO_FLAG_EN
   logic          zero_pend;
`endif

   // Carry-less product followed by top-down reduction modulo POLY.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      wide_t p;
      p = '0;
      for (int i = 0; i < M; i++)
         if (b[i]) p = p ^ (wide_t'(a) << i);
      for (int i = 2*M-2; i >= M; i--)
         if (p[i]) p = p ^ (wide_t'(POLY) << (i - M));
      return p[M-1:0];
   endfunction

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      case (state)
         IDLE: if (start) next_state = CALC;
         CALC: begin
            busy = 1'b1;
            if (cnt == CW'(1)) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // acc collects x^2 * x^4 * ... ; the final multiply lands directly in z.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         acc  <= '0;
         sq   <= '0;
         cnt  <= '0;
         z    <= '0;
         done <= 1'b0;
`ifdef GF_INV_ZERO_FLAG_EN
         zero_pend <= 1'b0;
         zero_err  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sq  <= gf_mul(x, x);
                  acc <= {{(M-1){1'b0}}, 1'b1};
                  cnt <= CW'(M - 1);
`ifdef GF_INV_ZERO_FLAG_EN
                  zero_pend <= (x == '0);
`endif
               end
            end
            CALC: begin
               acc <= gf_mul(acc, sq);
               sq  <= gf_mul(sq, sq);
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  z    <= gf_mul(acc, sq);
                  done <= 1'b1;
`ifdef GF_INV_ZERO_FLAG_EN
                  zero_err <= zero_pend;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2m_inverse_seq.sv
// Self-checking bench for gf2m_inverse_seq: M=6 and M=4 instances against a log/antilog reference.
module tb_gf2m_inverse_seq;

   logic       clk = 1'b0;
   logic       resetN;
   logic       start6, start4;
   logic [5:0] x6, z6;
   logic [3:0] x4, z4;
   logic       busy6, done6, busy4, done4;
`ifdef GF_INV_ZERO_FLAG_EN
   logic       zero_err6, zero_err4;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gf2m_inverse_seq #(.M(6), .POLY(7'b1000011)) dut6 (
      .clk(clk), .resetN(resetN), .start(start6), .x(x6),
      .busy(busy6), .done(done6), .z(z6)
`ifdef GF_INV_ZERO_FLAG_EN
      , .zero_err(zero_err6)
`endif
   );

   gf2m_inverse_seq #(.M(4), .POLY(5'b10011)) dut4 (
      .clk(clk), .resetN(resetN), .start(start4), .x(x4),
      .busy(busy4), .done(done4), .z(z4)
`ifdef GF_INV_ZERO_FLAG_EN
      , .zero_err(zero_err4)
`endif
   );

   // Inverse via discrete log: x = alpha^k  =>  1/x = alpha^((n-k) mod n).
   function automatic int ref_inv(int m, int poly, int xv);
      int n, e, k;
      n = (1 << m) - 1;
      e = 1;
      k = 0;
      if (xv == 0) return 0;
      for (int i = 0; i < n; i++) begin
         if (e == xv) k = i;
         e = e << 1;
         if ((e & (1 << m)) != 0) e = e ^ poly;
      end
      e = 1;
      for (int i = 0; i < (n - k) % n; i++) begin
         e = e << 1;
         if ((e & (1 << m)) != 0) e = e ^ poly;
      end
      return e;
   endfunction

   function automatic logic [31:0] cur_done(int m);
      return (m == 6) ? {31'b0, done6} : {31'b0, done4};
   endfunction

   function automatic logic [31:0] cur_busy(int m);
      return (m == 6) ? {31'b0, busy6} : {31'b0, busy4};
   endfunction

   function automatic logic [31:0] cur_z(int m);
      return (m == 6) ? {26'b0, z6} : {28'b0, z4};
   endfunction

`ifdef GF_INV_ZERO_FLAG_EN
   function automatic logic [31:0] cur_zero(int m);
      return (m == 6) ? {31'b0, zero_err6} : {31'b0, zero_err4};
   endfunction
`endif

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One accepted start, then latency, busy, result and flag checks; ends in the done cycle.
   task automatic applyStimulus(input int m, input int v);
      int          lat;
      logic [31:0] exp_z;
      exp_z = ref_inv(m, (m == 6) ? 'h43 : 'h13, v);
      if (m == 6) begin start6 = 1'b1; x6 = 6'(v); end
      else        begin start4 = 1'b1; x4 = 4'(v); end
      tick;
      start6 = 1'b0;
      start4 = 1'b0;
      x6 = 6'($urandom);
      x4 = 4'($urandom);
      lat = 0;
      while (cur_done(m) !== 32'd1 && lat < 20) begin
         checkOutput($sformatf("busy_m%0d_x%0d_c%0d", m, v, lat), cur_busy(m), 32'd1);
         tick;
         lat++;
      end
      checkOutput($sformatf("latency_m%0d_x%0d", m, v), lat, m - 1);
      checkOutput($sformatf("busy_done_m%0d_x%0d", m, v), cur_busy(m), 32'd0);
      checkOutput($sformatf("z_m%0d_x%0d", m, v), cur_z(m), exp_z);
`ifdef GF_INV_ZERO_FLAG_EN
      checkOutput($sformatf("zero_err_m%0d_x%0d", m, v), cur_zero(m), (v == 0) ? 32'd1 : 32'd0);
`endif
   endtask

   initial begin
      resetN = 1'b0;
      start6 = 1'b0; start4 = 1'b0;
      x6 = '0; x4 = '0;
      tick;
      tick;
      resetN = 1'b1;

      for (int c = 0; c < 10; c++) begin
         checkOutput("idle_busy", busy6, 32'd0);
         checkOutput("idle_done", done6, 32'd0);
         checkOutput("idle_z", z6, 32'd0);
`ifdef GF_INV_ZERO_FLAG_EN
         checkOutput("idle_zero_err", zero_err6, 32'd0);
`endif
         tick;
      end

      applyStimulus(6, 2);
      checkOutput("z_x02_const", z6, 32'h21);

      applyStimulus(6, 3);
      checkOutput("z_x03_const", z6, 32'h3E);
      applyStimulus(6, 1);
      checkOutput("z_x01_const", z6, 32'h01);
      tick;
      checkOutput("done_drop", done6, 32'd0);
      checkOutput("z_hold", z6, 32'h01);

      applyStimulus(6, 0);
      checkOutput("z_x00_const", z6, 32'h00);
      tick;

      start6 = 1'b1; x6 = 6'h05;
      tick;
      start6 = 1'b0;
      tick;
      start6 = 1'b1; x6 = 6'h3F;
      tick;
      start6 = 1'b0;
      checkOutput("midop_busy", busy6, 32'd1);
      resetN = 1'b0;
      #1;
      checkOutput("rst_busy", busy6, 32'd0);
      checkOutput("rst_done", done6, 32'd0);
      checkOutput("rst_z", z6, 32'd0);
      tick;
      resetN = 1'b1;
      for (int c = 0; c < 8; c++) begin
         checkOutput("post_rst_done", done6, 32'd0);
         checkOutput("post_rst_busy", busy6, 32'd0);
         tick;
      end

      for (int v = 1; v < 64; v++) applyStimulus(6, v);
      for (int v = 0; v < 16; v++) applyStimulus(4, v);

      for (int r = 0; r < 16; r++) begin
         applyStimulus(6, int'($urandom_range(63, 0)));
         applyStimulus(4, int'($urandom_range(15, 0)));
      end
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
